fm_voice_bank: RTL and testbench
================================

Name: fm_voice_bank

Overview:
- Parametrised successor to the single LFO-modulated sine synth.
- Runs NUM_VOICES independent voices, each a carrier oscillator frequency-modulated by its own LFO with programmable signed depth.
- Voices are time-multiplexed over one shared sine LUT and mixed into one saturated output sample per sample tick.
- Sits between the register/config front end and the audio output DAC path.

Parameters:
- NUM_VOICES, 4: number of voices; must be ≥1.
- PHASE_W, 32: phase accumulator and FCW width.
- LUT_ADDR_W, 10: sine LUT address width; the LUT index is the top LUT_ADDR_W bits of the phase.
- SAMPLE_W, 16: signed sample width, for LUT output and mixed output.
- DEPTH_W, 8: unsigned FM depth width.
- DEPTH_SHIFT, 8: left shift applied to the LFO×depth product.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle request to compute the next output sample.
- cfg_we  in  1  config write strobe.
- cfg_voice  in  $clog2(NUM_VOICES)  voice select for the write.
- cfg_enable  in  1  voice enable.
- cfg_base_fcw  in  PHASE_W  carrier frequency control word.
- cfg_lfo_fcw  in  PHASE_W  LFO frequency control word.
- cfg_depth  in  DEPTH_W  FM depth, unsigned.
- out_sample  out  SAMPLE_W  mixed signed sample.
- out_valid  out  1  one-cycle pulse when out_sample updates.
- busy  out  1  engine processing voices.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (asynchronous) clears:
  - all config registers, all LFO/carrier phases, and the accumulator;
  - out_sample=0, out_valid=0, busy=0, overrun=0;
  - FSM to IDLE.
- Config write: on a clk edge with cfg_we=1, all fields of the selected voice are written. They are visible to the engine from the next cycle. Writes are legal while busy. A write in the cycle the engine reads that voice takes effect at the next tick.
- FSM states: IDLE, LFO, CAR, ACC; voice counter v.
  - IDLE: on sample_tick, clear accumulator, set v=0, go to LFO.
  - LFO (voice v): if enabled, lfo_phase[v] += lfo_fcw[v], wrapping mod 2^PHASE_W. Register lfo_s = LUT[top bits of new lfo_phase].
  - CAR: fcw_eff = base_fcw + ((sext(lfo_s) × depth) <<< DEPTH_SHIFT), mod 2^PHASE_W, signed product. If enabled, car_phase[v] += fcw_eff. Register car_s = LUT[top bits of new car_phase].
  - ACC: if enabled, acc += sext(car_s). acc width is SAMPLE_W+$clog2(NUM_VOICES)+1. If v==NUM_VOICES-1, go to IDLE; otherwise v++ and go to LFO.
  - Disabled voices hold their phases and contribute 0, but still consume their 3 cycles.
- Latency: with the tick sampled in cycle 0, busy=1 in cycles 1..3·NUM_VOICES. out_sample and out_valid are registered at the end of the last ACC cycle, so out_valid=1 in cycle 3·NUM_VOICES+1 only.
- Output: out_sample = acc saturated to the signed SAMPLE_W range [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- sample_tick while busy: the tick is dropped, overrun is set, and the engine is unaffected. A tick in the same cycle as out_valid is accepted, since the FSM is already in IDLE.
- overrun clears only on reset.
- Reset mid-sequence aborts immediately. No out_valid is produced.

Optional Feature:
- FM_KEY_SYNC_EN defined: a config write to voice v also zeroes lfo_phase[v] and car_phase[v] on the same edge (note-on phase sync). The phase write has priority over any engine update to that voice in that cycle.
- Undefined: config writes never touch phases.

Decomposition:
- Package fm_synth_pkg holds:
  - FSM state enum (IDLE/LFO/CAR/ACC);
  - a voice config struct {enable, base_fcw, lfo_fcw, depth};
  - saturation limit constants derived from SAMPLE_W.
- One sub-module, sine_lut: combinational ROM with 2^LUT_ADDR_W signed entries. It holds one full sine period, with LUT[0]=0, LUT[N/4]=max and LUT[N/2]=0.
- The sub-module is instantiated once and shared by the LFO and CAR states.

Test Plan:
- Single voice: voice0 enabled, base_fcw=0x40000000, depth=0, others disabled; tick at cycle 0 → out_valid only at cycle 13, out_sample=32767. Second tick → 0. Third tick → -32767.
- Saturation: all 4 voices enabled at base_fcw=0x40000000, depth 0; tick → acc=131068, out_sample=32767. With base_fcw=0xC0000000 → out_sample=-32768 (clamped).
- FM path: voice0 base_fcw=0, lfo_fcw=0x40000000, depth=1. First tick → lfo_s=32767, fcw_eff=0x007FFF00, out_sample=LUT[1]. Check against the reference model over 8 ticks with depth 0/1/255.
- Overrun: tick in cycle 0 and again in cycle 5 → a single out_valid at cycle 13 and overrun=1 held. A tick in cycle 13 is accepted: next out_valid at cycle 26.
- Reset mid-op: assert reset in cycle 6 → busy, out_valid, overrun and phases go to 0 immediately. After release, the single-voice test reproduces its first-tick values.
- FM_KEY_SYNC_EN: after 3 ticks on voice0, rewrite voice0 config → next tick yields out_sample equal to the first-tick value. Without the macro, it continues the sequence.

Source files
------------

// File: rtl/fm_synth_pkg.sv
// Shared types and constants for the FM voice bank: engine states, per-voice config, output limits.
package fm_synth_pkg;

    localparam int PKG_PHASE_W  = 32;
    localparam int PKG_DEPTH_W  = 8;
    localparam int PKG_SAMPLE_W = 16;

    localparam int SAT_MAX = (1 << (PKG_SAMPLE_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (PKG_SAMPLE_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        LFO,
        CAR,
        ACC
    } engine_state_e;

    typedef struct packed {
        logic                   enable;
        logic [PKG_PHASE_W-1:0] base_fcw;
        logic [PKG_PHASE_W-1:0] lfo_fcw;
        logic [PKG_DEPTH_W-1:0] depth;
    } voice_cfg_t;

endpackage

// File: rtl/fm_voice_bank_sine_lut.sv
// Combinational sine ROM: one full period, entries rounded to the nearest integer of max*sin(2*pi*i/N).
module sine_lut
    import fm_synth_pkg::*;
#(
    parameter int LUT_ADDR_W = 10,
    parameter int SAMPLE_W   = PKG_SAMPLE_W
) (
    input  logic [LUT_ADDR_W-1:0]      addr_i,
    output logic signed [SAMPLE_W-1:0] data_o
);

    localparam int  DEPTH = 1 << LUT_ADDR_W;
    localparam real PI    = 3.141592653589793;
    localparam real AMP   = real'((1 << (SAMPLE_W - 1)) - 1);

    // Round half away from zero so the table is symmetric about the zero crossings.
    function automatic logic signed [SAMPLE_W-1:0] sineEntry(input int idx);
        real x;
        int  r;
        x = $sin(2.0 * PI * real'(idx) / real'(DEPTH)) * AMP;
        if (x >= 0.0) r = $rtoi(x + 0.5);
        else          r = -$rtoi(0.5 - x);
        return SAMPLE_W'(r);
    endfunction

    logic signed [SAMPLE_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic signed [SAMPLE_W-1:0] ENTRY = sineEntry(i);
        assign rom[i] = ENTRY;
    end

    assign data_o = rom[addr_i];

endmodule

// File: rtl/fm_voice_bank.sv
// Time-multiplexed bank of LFO-modulated FM voices sharing one sine LUT, mixed and saturated per tick.
// Build option: define FM_KEY_SYNC_EN to zero a voice's phases whenever its config is written.
module fm_voice_bank
    import fm_synth_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_W     = PKG_PHASE_W,
    parameter int LUT_ADDR_W  = 10,
    parameter int SAMPLE_W    = PKG_SAMPLE_W,
    parameter int DEPTH_W     = PKG_DEPTH_W,
    parameter int DEPTH_SHIFT = 8,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic                       cfg_we,
    input  logic [VW-1:0]              cfg_voice,
    input  logic                       cfg_enable,
    input  logic [PHASE_W-1:0]         cfg_base_fcw,
    input  logic [PHASE_W-1:0]         cfg_lfo_fcw,
    input  logic [DEPTH_W-1:0]         cfg_depth,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = SAMPLE_W + DEPTH_W + 1;
    localparam logic [VW-1:0]           LAST_V  = VW'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

    voice_cfg_t                 cfg_q [NUM_VOICES];
    logic [PHASE_W-1:0]         lfoPhase_q [NUM_VOICES];
    logic [PHASE_W-1:0]         carPhase_q [NUM_VOICES];

    voice_cfg_t                 curCfg_q;
    engine_state_e              state_q;
    logic [VW-1:0]              v_q;
    logic signed [SAMPLE_W-1:0] lfoS_q;
    logic signed [SAMPLE_W-1:0] carS_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [SAMPLE_W-1:0] outSample_q;
    logic                       outValid_q;
    logic                       busy_q;
    logic                       overrun_q;

    voice_cfg_t                 liveCfg;
    logic [PHASE_W-1:0]         lfoPhase_d;
    logic [PHASE_W-1:0]         carPhase_d;
    logic [PHASE_W-1:0]         fmOffset;
    logic signed [PROD_W-1:0]   fmProd;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [SAMPLE_W-1:0] satSample;
    logic [LUT_ADDR_W-1:0]      lutAddr;
    logic signed [SAMPLE_W-1:0] lutData;

    sine_lut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .SAMPLE_W   (SAMPLE_W)
    ) u_sine_lut (
        .addr_i (lutAddr),
        .data_o (lutData)
    );

    // CAR and ACC use the config snapshot taken in LFO, so a mid-voice write cannot split one voice's update.
    always_comb begin
        liveCfg    = cfg_q[v_q];
        lfoPhase_d = lfoPhase_q[v_q] + (liveCfg.enable ? liveCfg.lfo_fcw : '0);
        fmProd     = $signed({{(DEPTH_W + 1){lfoS_q[SAMPLE_W-1]}}, lfoS_q})
                   * $signed({{(SAMPLE_W + 1){1'b0}}, curCfg_q.depth});
        fmOffset   = {{(PHASE_W - PROD_W){fmProd[PROD_W-1]}}, fmProd} << DEPTH_SHIFT;
        carPhase_d = carPhase_q[v_q] + (curCfg_q.enable ? curCfg_q.base_fcw + fmOffset : '0);
        lutAddr    = (state_q == CAR) ? carPhase_d[PHASE_W-1 -: LUT_ADDR_W]
                                      : lfoPhase_d[PHASE_W-1 -: LUT_ADDR_W];
        acc_d      = acc_q + (curCfg_q.enable ? {{(ACC_W - SAMPLE_W){carS_q[SAMPLE_W-1]}}, carS_q} : '0);
        if (acc_d > ACC_MAX)      satSample = SAMPLE_W'(SAT_MAX);
        else if (acc_d < ACC_MIN) satSample = SAMPLE_W'(SAT_MIN);
        else                      satSample = acc_d[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cfg_q[i]      <= '0;
                lfoPhase_q[i] <= '0;
                carPhase_q[i] <= '0;
            end
        end else begin
            if (state_q == LFO) lfoPhase_q[v_q] <= lfoPhase_d;
            if (state_q == CAR) carPhase_q[v_q] <= carPhase_d;
            if (cfg_we) begin
                cfg_q[cfg_voice] <= '{enable:   cfg_enable,
                                      base_fcw: cfg_base_fcw,
                                      lfo_fcw:  cfg_lfo_fcw,
                                      depth:    cfg_depth};
`ifdef FM_KEY_SYNC_EN
                lfoPhase_q[cfg_voice] <= '0;
                carPhase_q[cfg_voice] <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            v_q         <= '0;
            curCfg_q    <= '0;
            lfoS_q      <= '0;
            carS_q      <= '0;
            acc_q       <= '0;
            outSample_q <= '0;
            outValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            if (sample_tick && busy_q) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        acc_q   <= '0;
                        v_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LFO;
                    end
                end
                LFO: begin
                    curCfg_q <= liveCfg;
                    lfoS_q   <= lutData;
                    state_q  <= CAR;
                end
                CAR: begin
                    carS_q  <= lutData;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (v_q == LAST_V) begin
                        outSample_q <= satSample;
                        outValid_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        v_q     <= v_q + 1'b1;
                        state_q <= LFO;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_sample = outSample_q;
    assign out_valid  = outValid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fm_voice_bank.sv
// Self-checking bench for fm_voice_bank against a per-tick arithmetic model of the voice bank.
module tb_fm_voice_bank;

    localparam int  NV = 4;
    localparam real PI = 3.141592653589793;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_voice = '0;
    logic               cfg_enable = 1'b0;
    logic [31:0]        cfg_base_fcw = '0;
    logic [31:0]        cfg_lfo_fcw = '0;
    logic [7:0]         cfg_depth = '0;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checkCount = 0;
    int passCount  = 0;

    bit [31:0] mLfo [NV];
    bit [31:0] mCar [NV];
    bit [31:0] mBase [NV];
    bit [31:0] mLfoFcw [NV];
    bit        mEn [NV];
    int        mDepth [NV];

    fm_voice_bank dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_enable   (cfg_enable),
        .cfg_base_fcw (cfg_base_fcw),
        .cfg_lfo_fcw  (cfg_lfo_fcw),
        .cfg_depth    (cfg_depth),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Ideal sine table value, rounded half away from zero.
    function automatic int lutVal(input int idx);
        real x;
        x = $sin(2.0 * PI * real'(idx) / real'(1024)) * 32767.0;
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic modelReset();
        for (int v = 0; v < NV; v++) begin
            mLfo[v] = 0; mCar[v] = 0; mBase[v] = 0; mLfoFcw[v] = 0; mEn[v] = 0; mDepth[v] = 0;
        end
    endtask

    // One sample: every enabled voice advances its LFO, then its carrier by base + lfo*depth*256, and is summed.
    task automatic modelTick(output int expSample);
        longint acc;
        longint fm;
        int     ls;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            if (mEn[v]) begin
                mLfo[v] = mLfo[v] + mLfoFcw[v];
                ls      = lutVal(int'(mLfo[v] >> 22));
                fm      = longint'(ls) * longint'(mDepth[v]) * 256;
                mCar[v] = mCar[v] + mBase[v] + fm[31:0];
                acc     = acc + longint'(lutVal(int'(mCar[v] >> 22)));
            end
        end
        if (acc > 32767)       expSample = 32767;
        else if (acc < -32768) expSample = -32768;
        else                   expSample = int'(acc);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic writeVoice(input int v, input bit en, input bit [31:0] base, input bit [31:0] lfo, input int depth);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_enable = en;
        cfg_base_fcw = base; cfg_lfo_fcw = lfo; cfg_depth = 8'(depth);
        @(negedge clk);
        cfg_we = 1'b0;
        mEn[v] = en; mBase[v] = base; mLfoFcw[v] = lfo; mDepth[v] = depth;
`ifdef FM_KEY_SYNC_EN
        mLfo[v] = 0; mCar[v] = 0;
`endif
    endtask

    // Tick in cycle 0, then watch cycles 1..18 for out_valid pulses and busy shape.
    task automatic runTick(output int validCycle, output int pulses, output logic signed [15:0] smp, output int busyErr);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        validCycle = -1; pulses = 0; busyErr = 0; smp = 'x;
        for (int c = 1; c <= 3 * NV + 6; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid === 1'b1) begin
                pulses++;
                if (validCycle < 0) begin validCycle = c; smp = out_sample; end
            end
            if ((busy === 1'b1) != (c <= 3 * NV)) busyErr++;
        end
    endtask

    task automatic test_reset();
        applyReset();
        checkCount++; if (out_sample !== 16'sd0) $display("FAIL reset.out_sample got %0d expected 0", out_sample); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL reset.out_valid got %b expected 0", out_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL reset.busy got %b expected 0", busy); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("FAIL reset.overrun got %b expected 0", overrun); else passCount++;
    endtask

    task automatic test_single_voice();
        int vc, np, be, exp;
        int fixedExp [3];
        logic signed [15:0] smp;
        fixedExp[0] = 32767; fixedExp[1] = 0; fixedExp[2] = -32767;
        applyReset();
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            runTick(vc, np, smp, be);
            modelTick(exp);
            checkCount++; if (vc !== 13) $display("FAIL single.latency tick%0d got cycle %0d expected 13", k, vc); else passCount++;
            checkCount++; if (np !== 1) $display("FAIL single.pulses tick%0d got %0d expected 1", k, np); else passCount++;
            checkCount++; if (be !== 0) $display("FAIL single.busy tick%0d got %0d bad cycles expected 0", k, be); else passCount++;
            checkCount++; if (smp !== fixedExp[k]) $display("FAIL single.sample tick%0d got %0d expected %0d", k, smp, fixedExp[k]); else passCount++;
            checkCount++; if (smp !== exp) $display("FAIL single.model tick%0d got %0d expected %0d", k, smp, exp); else passCount++;
        end
    endtask

    task automatic test_saturation();
        int vc, np, be, exp;
        logic signed [15:0] smp;
        applyReset();
        for (int v = 0; v < NV; v++) writeVoice(v, 1'b1, 32'h4000_0000, 32'h0, 0);
        runTick(vc, np, smp, be);
        modelTick(exp);
        checkCount++; if (smp !== 16'sd32767) $display("FAIL sat.positive got %0d expected 32767", smp); else passCount++;
        checkCount++; if (smp !== exp) $display("FAIL sat.positive_model got %0d expected %0d", smp, exp); else passCount++;
        applyReset();
        for (int v = 0; v < NV; v++) writeVoice(v, 1'b1, 32'hC000_0000, 32'h0, 0);
        runTick(vc, np, smp, be);
        modelTick(exp);
        checkCount++; if (smp !== -16'sd32768) $display("FAIL sat.negative got %0d expected -32768", smp); else passCount++;
        checkCount++; if (smp !== exp) $display("FAIL sat.negative_model got %0d expected %0d", smp, exp); else passCount++;
    endtask

    task automatic test_fm_path();
        int vc, np, be, exp;
        int depths [3];
        logic signed [15:0] smp;
        depths[0] = 0; depths[1] = 1; depths[2] = 255;
        applyReset();
        writeVoice(0, 1'b1, 32'h0, 32'h4000_0000, 1);
        runTick(vc, np, smp, be);
        modelTick(exp);
        checkCount++; if (smp !== lutVal(1)) $display("FAIL fm.first got %0d expected %0d", smp, lutVal(1)); else passCount++;
        checkCount++; if (smp !== exp) $display("FAIL fm.first_model got %0d expected %0d", smp, exp); else passCount++;
        for (int t = 0; t < 8; t++) begin
            writeVoice(t % NV, ($urandom_range(0, 3) != 0), $urandom & 32'h0FFF_FFFF,
                       $urandom & 32'h0FFF_FFFF, depths[t % 3]);
            runTick(vc, np, smp, be);
            modelTick(exp);
            checkCount++; if (vc !== 13) $display("FAIL fm.latency t%0d got cycle %0d expected 13", t, vc); else passCount++;
            checkCount++; if (smp !== exp) $display("FAIL fm.model t%0d depth %0d got %0d expected %0d", t, depths[t % 3], smp, exp); else passCount++;
        end
    endtask

    task automatic test_overrun();
        int validAt [$];
        int samples [$];
        int exp0, exp1;
        applyReset();
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid === 1'b1) begin validAt.push_back(c); samples.push_back(int'(out_sample)); end
            if (c == 5) begin
                checkCount++; if (overrun !== 1'b0) $display("FAIL ovr.before got %b expected 0", overrun); else passCount++;
            end
            if (c == 6) begin
                checkCount++; if (overrun !== 1'b1) $display("FAIL ovr.set got %b expected 1", overrun); else passCount++;
            end
            sample_tick = (c == 0 || c == 5 || c == 13);
        end
        sample_tick = 1'b0;
        modelTick(exp0);
        modelTick(exp1);
        checkCount++; if (validAt.size() !== 2) $display("FAIL ovr.pulse_count got %0d expected 2", validAt.size()); else passCount++;
        if (validAt.size() == 2) begin
            checkCount++; if (validAt[0] !== 13) $display("FAIL ovr.first_valid got cycle %0d expected 13", validAt[0]); else passCount++;
            checkCount++; if (validAt[1] !== 26) $display("FAIL ovr.second_valid got cycle %0d expected 26", validAt[1]); else passCount++;
            checkCount++; if (samples[0] !== exp0) $display("FAIL ovr.first_sample got %0d expected %0d", samples[0], exp0); else passCount++;
            checkCount++; if (samples[1] !== exp1) $display("FAIL ovr.second_sample got %0d expected %0d", samples[1], exp1); else passCount++;
        end
        checkCount++; if (overrun !== 1'b1) $display("FAIL ovr.sticky got %b expected 1", overrun); else passCount++;
    endtask

    task automatic test_reset_midop();
        int vc, np, be, exp, stray;
        logic signed [15:0] smp;
        applyReset();
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        runTick(vc, np, smp, be);
        modelTick(exp);
        checkCount++; if (smp !== exp) $display("FAIL rst.pre_sample got %0d expected %0d", smp, exp); else passCount++;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            sample_tick = (c == 0 || c == 3);
        end
        sample_tick = 1'b0;
        checkCount++; if (busy !== 1'b1 || overrun !== 1'b1) $display("FAIL rst.pre_state got busy=%b overrun=%b expected 1/1", busy, overrun); else passCount++;
        reset = 1'b1;
        #1;
        checkCount++; if (busy !== 1'b0) $display("FAIL rst.busy got %b expected 0", busy); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL rst.out_valid got %b expected 0", out_valid); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("FAIL rst.overrun got %b expected 0", overrun); else passCount++;
        checkCount++; if (out_sample !== 16'sd0) $display("FAIL rst.out_sample got %0d expected 0", out_sample); else passCount++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        stray = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        checkCount++; if (stray !== 0) $display("FAIL rst.no_valid got %0d pulses expected 0", stray); else passCount++;
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        runTick(vc, np, smp, be);
        modelTick(exp);
        checkCount++; if (smp !== 16'sd32767) $display("FAIL rst.after_sample got %0d expected 32767", smp); else passCount++;
        checkCount++; if (vc !== 13) $display("FAIL rst.after_latency got cycle %0d expected 13", vc); else passCount++;
    endtask

    task automatic test_key_sync();
        int vc, np, be, exp, fixedExp;
        logic signed [15:0] smp;
        applyReset();
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            runTick(vc, np, smp, be);
            modelTick(exp);
            checkCount++; if (smp !== exp) $display("FAIL sync.pre tick%0d got %0d expected %0d", k, smp, exp); else passCount++;
        end
        writeVoice(0, 1'b1, 32'h4000_0000, 32'h0, 0);
        runTick(vc, np, smp, be);
        modelTick(exp);
`ifdef FM_KEY_SYNC_EN
        fixedExp = 32767;
`else
        fixedExp = 0;
`endif
        checkCount++; if (smp !== fixedExp) $display("FAIL sync.after got %0d expected %0d", smp, fixedExp); else passCount++;
        checkCount++; if (smp !== exp) $display("FAIL sync.after_model got %0d expected %0d", smp, exp); else passCount++;
    endtask

    initial begin
        modelReset();
        $display("[TB] fm_voice_bank bench start");
        test_reset();
        test_single_voice();
        test_saturation();
        test_fm_path();
        test_overrun();
        test_reset_midop();
        test_key_sync();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
